// File: rtl/pulse_bcd_counter_pkg.sv
// Shared constants and helpers for the pulse-driven BCD counter and its display.
// Latency: n/a (combinational helpers only).
// Backpressure: n/a.
package pulse_bcd_counter_pkg;

  localparam int CLK_HZ = 50_000_000;

  // Active-low segment glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low digit selects
  localparam logic [1:0] AN_ONES = 2'b10;
  localparam logic [1:0] AN_TENS = 2'b01;

  // Non-BCD codes render blank so a corrupted digit is visible, not misleading
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
    logic [6:0] glyph;
    case (digit)
      4'd0:    glyph = SEG_0;
      4'd1:    glyph = SEG_1;
      4'd2:    glyph = SEG_2;
      4'd3:    glyph = SEG_3;
      4'd4:    glyph = SEG_4;
      4'd5:    glyph = SEG_5;
      4'd6:    glyph = SEG_6;
      4'd7:    glyph = SEG_7;
      4'd8:    glyph = SEG_8;
      4'd9:    glyph = SEG_9;
      default: glyph = SEG_BLANK;
    endcase
    return glyph;
  endfunction

  // A pattern is loadable only if it lies within 00..{max_tens,max_ones}
  function automatic logic bcd_valid(input logic [7:0] value,
                                     input logic [3:0] max_tens,
                                     input logic [3:0] max_ones);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = value[7:4];
    ones = value[3:0];
    return (tens <= max_tens) && (ones <= 4'd9) &&
           ((tens != max_tens) || (ones <= max_ones));
  endfunction

endpackage

// File: rtl/pulse_bcd_counter_seg_scan.sv
// Two-digit multiplexed 7-segment driver: alternates digits every SCAN_DIV clocks.
// Latency: seg/an registered; seg reflects bcd_in one clock later, same edge as an.
// Backpressure: none; free-running scan.
module pulse_bcd_counter_seg_scan
  import pulse_bcd_counter_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int SCAN_W   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] bcd_in,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic [SCAN_W-1:0] scan_cnt;
  logic              scan_wrap;
  logic [1:0]        an_nxt;
  logic [3:0]        digit_nxt;

  // Next digit select, and the digit that will be lit under it
  always_comb begin
    scan_wrap = (scan_cnt == SCAN_LAST);
    an_nxt    = scan_wrap ? ~an : an;
    digit_nxt = (an_nxt == AN_ONES) ? bcd_in[3:0] : bcd_in[7:4];
  end

  // Scan counter, digit select and decoded segments all move on one edge
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      an       <= AN_ONES;
      seg      <= SEG_0;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + SCAN_W'(1);
      an       <= an_nxt;
      seg      <= bcd_to_seg(digit_nxt);
    end
  end

endmodule

// File: rtl/pulse_bcd_counter.sv
// Two-digit BCD modulo counter advanced by a one-cycle enable strobe, with display.
// Latency: bcd_out/carry/load_err update on the edge that samples the strobe/load.
// Backpressure: none; strobes arriving while held, cleared or loading are dropped.
module pulse_bcd_counter
  import pulse_bcd_counter_pkg::*;
#(
  parameter int MAX_TENS = 5,
  parameter int MAX_ONES = 9,
  parameter int SCAN_DIV = 50000,
  parameter int SCAN_W   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cnt_en,
  input  logic       run,
  input  logic       up_dn,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] bcd_out,
  output logic       carry,
  output logic       load_err,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam logic [3:0] T_TENS = 4'(MAX_TENS);
  localparam logic [3:0] T_ONES = 4'(MAX_ONES);

  logic [3:0] tens;
  logic [3:0] ones;
  logic [3:0] tens_nxt;
  logic [3:0] ones_nxt;
  logic       carry_nxt;
  logic       load_err_nxt;
  logic       count_go;
  logic       at_top;
  logic       at_zero;

  assign bcd_out = {tens, ones};

  // Next count: clr beats load beats count; otherwise hold
  always_comb begin
    tens_nxt     = tens;
    ones_nxt     = ones;
    carry_nxt    = 1'b0;
    load_err_nxt = 1'b0;
    count_go     = cnt_en && run && !clr && !load;
    at_top       = (tens == T_TENS) && (ones == T_ONES);
    at_zero      = (tens == 4'd0) && (ones == 4'd0);
    if (clr) begin
      tens_nxt = 4'd0;
      ones_nxt = 4'd0;
    end else if (load) begin
      if (bcd_valid(load_val, T_TENS, T_ONES)) begin
        tens_nxt = load_val[7:4];
        ones_nxt = load_val[3:0];
      end else begin
        load_err_nxt = 1'b1;
      end
    end else if (count_go) begin
      if (up_dn) begin
        if (at_top) begin
          tens_nxt  = 4'd0;
          ones_nxt  = 4'd0;
          carry_nxt = 1'b1;
        end else if (ones == 4'd9) begin
          tens_nxt = tens + 4'd1;
          ones_nxt = 4'd0;
        end else begin
          ones_nxt = ones + 4'd1;
        end
      end else begin
        if (at_zero) begin
          tens_nxt  = T_TENS;
          ones_nxt  = T_ONES;
          carry_nxt = 1'b1;
        end else if (ones == 4'd0) begin
          tens_nxt = tens - 4'd1;
          ones_nxt = 4'd9;
        end else begin
          ones_nxt = ones - 4'd1;
        end
      end
    end
  end

  // Count register and single-cycle status strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      tens     <= 4'd0;
      ones     <= 4'd0;
      carry    <= 1'b0;
      load_err <= 1'b0;
    end else begin
      tens     <= tens_nxt;
      ones     <= ones_nxt;
      carry    <= carry_nxt;
      load_err <= load_err_nxt;
    end
  end

  pulse_bcd_counter_seg_scan #(
    .SCAN_DIV (SCAN_DIV),
    .SCAN_W   (SCAN_W)
  ) u_seg_scan (
    .clk    (clk),
    .rst    (rst),
    .bcd_in (bcd_out),
    .seg    (seg),
    .an     (an)
  );

endmodule

// File: tb/tb_pulse_bcd_counter.sv
// Directed bench for pulse_bcd_counter with hand-computed expectations.
// Latency: outputs sampled 1 ns after each rising edge.
// Backpressure: n/a.
module tb_pulse_bcd_counter;

  logic       clk;
  logic       rst;
  logic       cnt_en;
  logic       run;
  logic       up_dn;
  logic       clr;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] bcd_out;
  logic       carry;
  logic       load_err;
  logic [6:0] seg;
  logic [1:0] an;

  int vec_cnt;
  int err_cnt;

  pulse_bcd_counter #(
    .MAX_TENS (5),
    .MAX_ONES (9),
    .SCAN_DIV (4),
    .SCAN_W   (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cnt_en   (cnt_en),
    .run      (run),
    .up_dn    (up_dn),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .bcd_out  (bcd_out),
    .carry    (carry),
    .load_err (load_err),
    .seg      (seg),
    .an       (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One-cycle cnt_en; outputs of the sampling edge are visible on return
  task automatic strobe();
    cnt_en = 1'b1;
    tick();
    cnt_en = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] v);
    load_val = v;
    load     = 1'b1;
    tick();
    load     = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_bcd;
    logic [1:0] prev_an;
    int         run_len;

    vec_cnt  = 0;
    err_cnt  = 0;
    rst      = 1'b1;
    cnt_en   = 1'b0;
    run      = 1'b0;
    up_dn    = 1'b1;
    clr      = 1'b0;
    load     = 1'b0;
    load_val = 8'h00;
    idle(2);

    chk("rst_bcd",   32'(bcd_out),  32'h00);
    chk("rst_carry", 32'(carry),    32'h0);
    chk("rst_lerr",  32'(load_err), 32'h0);
    chk("rst_an",    32'(an),       32'h2);
    chk("rst_seg",   32'(seg),      32'h40);

    // Up count 00..59 with no carry, then wrap to 00 with one-cycle carry
    rst   = 1'b0;
    run   = 1'b1;
    up_dn = 1'b1;
    for (int i = 1; i <= 59; i++) begin
      exp_bcd = {4'(i / 10), 4'(i % 10)};
      strobe();
      chk("up_bcd",   32'(bcd_out), 32'(exp_bcd));
      chk("up_carry", 32'(carry),   32'h0);
      idle(4);
    end
    strobe();
    chk("upwrap_bcd",   32'(bcd_out), 32'h00);
    chk("upwrap_carry", 32'(carry),   32'h1);
    tick();
    chk("upwrap_carry_drop", 32'(carry), 32'h0);
    idle(3);

    // Down count through a tens borrow, then wrap below 00
    do_load(8'h10);
    chk("ld10", 32'(bcd_out), 32'h10);
    up_dn = 1'b0;
    strobe();
    chk("dn_09", 32'(bcd_out), 32'h09);
    idle(4);
    strobe();
    chk("dn_08", 32'(bcd_out), 32'h08);
    idle(4);
    do_load(8'h00);
    chk("ld00", 32'(bcd_out), 32'h00);
    strobe();
    chk("dnwrap_bcd",   32'(bcd_out), 32'h59);
    chk("dnwrap_carry", 32'(carry),   32'h1);

    // Reset in the cycle after the wrap strobe
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_bcd",   32'(bcd_out), 32'h00);
    chk("midrst_carry", 32'(carry),   32'h0);
    chk("midrst_an",    32'(an),      32'h2);
    chk("midrst_seg",   32'(seg),     32'h40);

    // Invalid loads rejected, valid terminal value accepted
    do_load(8'h6A);
    chk("bad6A_err", 32'(load_err), 32'h1);
    chk("bad6A_bcd", 32'(bcd_out),  32'h00);
    tick();
    chk("bad6A_err_drop", 32'(load_err), 32'h0);
    do_load(8'h3C);
    chk("bad3C_err", 32'(load_err), 32'h1);
    chk("bad3C_bcd", 32'(bcd_out),  32'h00);
    cnt_en = 1'b1;
    do_load(8'h6A);
    cnt_en = 1'b0;
    chk("bad_cnt_bcd", 32'(bcd_out), 32'h00);
    do_load(8'h59);
    chk("ld59_err", 32'(load_err), 32'h0);
    chk("ld59_bcd", 32'(bcd_out),  32'h59);

    // Priority: clr over cnt_en, load over cnt_en, run=0 drops strobes
    do_load(8'h23);
    chk("ld23", 32'(bcd_out), 32'h23);
    up_dn  = 1'b1;
    clr    = 1'b1;
    cnt_en = 1'b1;
    tick();
    clr    = 1'b0;
    cnt_en = 1'b0;
    chk("clr_bcd",   32'(bcd_out), 32'h00);
    chk("clr_carry", 32'(carry),   32'h0);
    cnt_en = 1'b1;
    do_load(8'h45);
    cnt_en = 1'b0;
    chk("ld45_cnt", 32'(bcd_out), 32'h45);
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      strobe();
      chk("hold_bcd", 32'(bcd_out), 32'h45);
      idle(2);
    end
    run = 1'b1;
    tick();
    chk("hold_no_queue", 32'(bcd_out), 32'h45);

    // Display scan at SCAN_DIV=4 showing 47
    do_load(8'h47);
    idle(2);
    for (int k = 0; k < 4; k++) begin
      prev_an = an;
      run_len = 0;
      while (an == prev_an && run_len < 20) begin
        chk("scan_an_legal", 32'(an == 2'b10 || an == 2'b01), 32'h1);
        chk("scan_seg", 32'(seg), (an == 2'b10) ? 32'h78 : 32'h19);
        tick();
        run_len++;
      end
      if (k > 0) chk("scan_period", 32'(run_len), 32'd4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
